fwd_scoreboard: RTL and testbench

- Parametrised successor to the combinational forwarding unit, for a pipeline with variable-latency producers (ALU, multiplier, divider, load).
- Holds a per-register scoreboard with busy bit, latency countdown and producer-unit tag.
- At ID it decides, per source operand, one of three actions:
  - forward from a producer's bypass bus,
  - forward from the writeback bus,
  - stall.
- Sits beside the ID/EX register; its outputs drive the operand bypass muxes and the ID-stage stall.

---
 rtl/fwd_scoreboard.sv | 130 +++++++++++++
 tb/tb_fwd_scoreboard.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Register scoreboard for variable-latency producers.
// Decides, per ID source operand, bypass-bus forward, writeback forward or stall.
module fwd_scoreboard #(
   parameter int NREG   = 32,
   parameter int AW     = 5,
   parameter int MAXLAT = 7,
   parameter int LW     = 3,
   parameter int UW     = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rs,
   input  logic [AW-1:0]   issue_rt,
   input  logic            issue_uses_rs,
   input  logic            issue_uses_rt,
   input  logic            issue_regwr,
   input  logic [AW-1:0]   issue_rd,
   input  logic [LW-1:0]   issue_lat,
   input  logic [UW-1:0]   issue_unit,
   input  logic            flush,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   output logic            stall,
   output logic            rs_fwd_en,
   output logic [UW-1:0]   rs_fwd_unit,
   output logic            rs_fwd_wb,
   output logic            rt_fwd_en,
   output logic [UW-1:0]   rt_fwd_unit,
   output logic            rt_fwd_wb,
   output logic [NREG-1:0] busy_vec,
   output logic [AW:0]     busy_count
);

   typedef struct packed {
      logic          raw;
      logic          fwd_en;
      logic          fwd_wb;
      logic [UW-1:0] unit;
   } src_res_t;

   logic [NREG-1:0] busy_q, busy_d;
   logic [LW-1:0]   cnt_q  [NREG];
   logic [LW-1:0]   cnt_d  [NREG];
   logic [UW-1:0]   unit_q [NREG];
   logic [UW-1:0]   unit_d [NREG];
   logic [AW:0]     count_q, count_d;

   src_res_t        rs_res, rt_res;
   logic            waw, acc;
   logic [LW-1:0]   lat_sat;

   // Writeback hit outranks the bypass bus: the scoreboard entry is stale that cycle.
   function automatic src_res_t eval_src(input logic [AW-1:0] s, input logic uses);
      src_res_t r;
      r = '0;
      if (uses && s != '0) begin
         if (wb_valid && wb_rd == s) begin
            r.fwd_wb = 1'b1;
         end else if (busy_q[s] && cnt_q[s] == '0) begin
            r.fwd_en = 1'b1;
            r.unit   = unit_q[s];
         end else if (busy_q[s]) begin
            r.raw = 1'b1;
         end
      end
      return r;
   endfunction

   always_comb begin
      rs_res = eval_src(issue_rs, issue_uses_rs);
      rt_res = eval_src(issue_rt, issue_uses_rt);
      waw    = issue_regwr && issue_rd != '0 && busy_q[issue_rd] &&
               !(wb_valid && wb_rd == issue_rd);
      stall  = issue_valid && (rs_res.raw || rt_res.raw || waw);
      acc    = issue_valid && !stall && !flush;
      lat_sat = (int'(issue_lat) > MAXLAT) ? LW'(MAXLAT) : issue_lat;
   end

   assign rs_fwd_en   = rs_res.fwd_en;
   assign rs_fwd_unit = rs_res.unit;
   assign rs_fwd_wb   = rs_res.fwd_wb;
   assign rt_fwd_en   = rt_res.fwd_en;
   assign rt_fwd_unit = rt_res.unit;
   assign rt_fwd_wb   = rt_res.fwd_wb;

   // Later assignments win: countdown, then writeback clear, then new issue.
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      unit_d = unit_q;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (busy_q[i] && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - LW'(1);
      end
      if (wb_valid && wb_rd != '0) begin
         busy_d[wb_rd] = 1'b0;
         cnt_d[wb_rd]  = '0;
      end
      if (acc && issue_regwr && issue_rd != '0) begin
         busy_d[issue_rd] = 1'b1;
         cnt_d[issue_rd]  = lat_sat;
         unit_d[issue_rd] = issue_unit;
      end
      busy_d[0] = 1'b0;
      count_d = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         count_d = count_d + (AW+1)'(busy_d[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < NREG; i++) begin
            cnt_q[i]  <= '0;
            unit_q[i] <= '0;
         end
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
         cnt_q   <= cnt_d;
         unit_q  <= unit_d;
      end
   end

   assign busy_vec   = busy_q;
   assign busy_count = count_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: expected ID decisions are queued per step
// and popped when the combinational outputs have settled.
module tb_fwd_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid, issue_uses_rs, issue_uses_rt, issue_regwr, flush, wb_valid;
   logic [4:0]  issue_rs, issue_rt, issue_rd, wb_rd;
   logic [2:0]  issue_lat;
   logic [1:0]  issue_unit;
   logic        stall, rs_fwd_en, rs_fwd_wb, rt_fwd_en, rt_fwd_wb;
   logic [1:0]  rs_fwd_unit, rt_fwd_unit;
   logic [31:0] busy_vec;
   logic [5:0]  busy_count;

   typedef struct packed {
      logic       stall;
      logic       rs_en;
      logic [1:0] rs_unit;
      logic       rs_wb;
      logic       rt_en;
      logic [1:0] rt_unit;
      logic       rt_wb;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   fwd_scoreboard #(.NREG(32), .AW(5), .MAXLAT(7), .LW(3), .UW(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
      .issue_uses_rs(issue_uses_rs), .issue_uses_rt(issue_uses_rt),
      .issue_regwr(issue_regwr), .issue_rd(issue_rd), .issue_lat(issue_lat),
      .issue_unit(issue_unit), .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .stall(stall), .rs_fwd_en(rs_fwd_en), .rs_fwd_unit(rs_fwd_unit),
      .rs_fwd_wb(rs_fwd_wb), .rt_fwd_en(rt_fwd_en), .rt_fwd_unit(rt_fwd_unit),
      .rt_fwd_wb(rt_fwd_wb), .busy_vec(busy_vec), .busy_count(busy_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, want);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt, input logic rw,
                        input logic [4:0] rd, input logic [2:0] lat, input logic [1:0] un,
                        input logic fl, input logic wv, input logic [4:0] wrd);
      issue_valid = v;   issue_rs = rs; issue_uses_rs = urs;
      issue_rt = rt;     issue_uses_rt = urt;
      issue_regwr = rw;  issue_rd = rd; issue_lat = lat; issue_unit = un;
      flush = fl;        wb_valid = wv; wb_rd = wrd;
   endtask

   task automatic expect_o(input logic st, input logic rse, input logic [1:0] rsu,
                           input logic rsw, input logic rte, input logic [1:0] rtu,
                           input logic rtw);
      exp_t e;
      e = '{st, rse, rsu, rsw, rte, rtu, rtw};
      exp_q.push_back(e);
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      #2;
      total++;
      assert (exp_q.size() != 0) else begin
         bad++;
         $error("FAIL %s got=no_expectation exp=queued_entry", tag);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, ".stall"},   32'(stall),       32'(e.stall));
         chk({tag, ".rs_en"},   32'(rs_fwd_en),   32'(e.rs_en));
         chk({tag, ".rs_unit"}, 32'(rs_fwd_unit), 32'(e.rs_unit));
         chk({tag, ".rs_wb"},   32'(rs_fwd_wb),   32'(e.rs_wb));
         chk({tag, ".rt_en"},   32'(rt_fwd_en),   32'(e.rt_en));
         chk({tag, ".rt_unit"}, 32'(rt_fwd_unit), 32'(e.rt_unit));
         chk({tag, ".rt_wb"},   32'(rt_fwd_wb),   32'(e.rt_wb));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_busy(input string tag, input logic [31:0] vec, input logic [5:0] cnt);
      chk({tag, ".busy_vec"},   busy_vec,        vec);
      chk({tag, ".busy_count"}, 32'(busy_count), 32'(cnt));
   endtask

   initial begin
      // reset with a consumer already in ID
      rst_n = 1'b0;
      drive(1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 3'd0, 2'd0, 0, 0, 5'd0);
      #1;
      expect_o(0, 0, 2'd0, 0, 0, 2'd0, 0);
      check_out("reset");
      chk_busy("reset", 32'h0, 6'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // producer rd=5 lat=2 unit=1, then a held consumer of rs=5
      drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 3'd2, 2'd1, 0, 0, 5'd0);
      expect_o(0, 0, 2'd0, 0, 0, 2'd0, 0);
      check_out("issue5");
      tick();
      chk_busy("issue5", 32'h0000_0020, 6'd1);
      drive(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 3'd0, 2'd0, 0, 0, 5'd0);
      expect_o(1, 0, 2'd0, 0, 0, 2'd0, 0);
      check_out("raw_c1");
      tick();
      expect_o(1, 0, 2'd0, 0, 0, 2'd0, 0);
      check_out("raw_c2");
      tick();
      expect_o(0, 1, 2'd1, 0, 0, 2'd0, 0);
      check_out("raw_fwd");
      tick();

      // writeback of busy reg 5 while rt=5 consumer is in ID
      drive(1, 5'd0, 0, 5'd5, 1, 0, 5'd0, 3'd0, 2'd0, 0, 1, 5'd5);
      expect_o(0, 0, 2'd0, 0, 0, 2'd0, 1);
      check_out("wb_fwd");
      tick();
      chk_busy("wb_clear", 32'h0, 6'd0);

      // WAW: reg 5 busy with cnt=3, second writer waits for writeback
      drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 3'd3, 2'd2, 0, 0, 5'd0);
      expect_o(0, 0, 2'd0, 0, 0, 2'd0, 0);
      check_out("waw_first");
      tick();
      drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 3'd1, 2'd3, 0, 0, 5'd0);
      expect_o(1, 0, 2'd0, 0, 0, 2'd0, 0);
      check_out("waw_stall1");
      tick();
      expect_o(1, 0, 2'd0, 0, 0, 2'd0, 0);
      check_out("waw_stall2");
      chk_busy("waw_hold", 32'h0000_0020, 6'd1);
      wb_valid = 1'b1; wb_rd = 5'd5;
      expect_o(0, 0, 2'd0, 0, 0, 2'd0, 0);
      check_out("waw_accept");
      tick();
      chk_busy("waw_reissue", 32'h0000_0020, 6'd1);
      drive(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 3'd0, 2'd0, 0, 0, 5'd0);
      expect_o(1, 0, 2'd0, 0, 0, 2'd0, 0);
      check_out("waw_dep_stall");
      tick();
      expect_o(0, 1, 2'd3, 0, 0, 2'd0, 0);
      check_out("waw_newtag");
      tick();
      drive(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 3'd0, 2'd0, 0, 1, 5'd5);
      tick();
      chk_busy("clear5", 32'h0, 6'd0);

      // register 0 is never tracked
      drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 3'd4, 2'd1, 0, 0, 5'd0);
      expect_o(0, 0, 2'd0, 0, 0, 2'd0, 0);
      check_out("rd0_issue");
      tick();
      chk_busy("rd0", 32'h0, 6'd0);
      drive(1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 3'd0, 2'd0, 0, 0, 5'd0);
      expect_o(0, 0, 2'd0, 0, 0, 2'd0, 0);
      check_out("rs0_consumer");
      tick();

      // flushed issue is dropped; issue beats a same-cycle writeback
      drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 3'd5, 2'd2, 1, 0, 5'd0);
      tick();
      chk_busy("flush7", 32'h0, 6'd0);
      drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 3'd5, 2'd2, 0, 1, 5'd7);
      tick();
      chk_busy("issue_over_wb", 32'h0000_0080, 6'd1);
      drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd31, 3'd0, 2'd3, 0, 0, 5'd0);
      tick();
      chk_busy("two_busy", 32'h8000_0080, 6'd2);

      // mixed: rs forwards, rt stalls; flush does not mask the stall
      drive(1, 5'd31, 1, 5'd7, 1, 0, 5'd0, 3'd0, 2'd0, 0, 0, 5'd0);
      expect_o(1, 1, 2'd3, 0, 0, 2'd0, 0);
      check_out("mixed");
      flush = 1'b1;
      expect_o(1, 1, 2'd3, 0, 0, 2'd0, 0);
      check_out("mixed_flush");

      // asynchronous reset mid-operation, no clock edge
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_busy("async_rst", 32'h0, 6'd0);
      expect_o(0, 0, 2'd0, 0, 0, 2'd0, 0);
      check_out("async_rst_out");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
